cdb_arbiter: RTL

//  Common-data-bus arbiter between execution units (ALU, LSB, branch) and result consumers (ROB, RS, LSB).

---
 rtl/cdb_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter for the common data bus. Execution units (0=ALU, 1=LSB, 2=BR)
//   present finished results. At most one result is granted per cycle. The granted result
//   is broadcast on a registered CDB one cycle after its grant.
//   Results carrying ROB tag 0 have no consumer. They are accepted but not broadcast,
//   and each one is counted in a saturating drop counter.
//
// Ports
//   i_clk         system clock
//   i_rst         asynchronous reset, active-high
//   i_rdy         global pause when low: every register holds and no grant is issued
//   i_reset       synchronous branch-mispredict flush
//   i_req_valid   unit i holds a finished result
//   i_req_tag     ROB tag of unit i (slice i)
//   i_req_data    result value of unit i (slice i)
//   o_req_ready   combinational one-hot grant; the granted unit drops its result after the edge
//   o_cdb_valid   broadcast valid (registered)
//   o_cdb_tag     broadcast ROB tag
//   o_cdb_data    broadcast value
//   o_cdb_src     one-hot source unit of the current broadcast
//   o_drop_cnt    saturating count of discarded tag-0 results
module cdb_arbiter #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned ROB_SZ_LOG = 3,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_rdy,
    input  logic                            i_reset,
    input  logic [N_REQ-1:0]                i_req_valid,
    input  logic [N_REQ*(ROB_SZ_LOG+1)-1:0] i_req_tag,
    input  logic [N_REQ*DATA_W-1:0]         i_req_data,
    output logic [N_REQ-1:0]                o_req_ready,
    output logic                            o_cdb_valid,
    output logic [ROB_SZ_LOG:0]             o_cdb_tag,
    output logic [DATA_W-1:0]               o_cdb_data,
    output logic [N_REQ-1:0]                o_cdb_src,
    output logic [7:0]                      o_drop_cnt
);

    localparam int unsigned TagW = ROB_SZ_LOG + 1;
    localparam int unsigned PtrW = $clog2(N_REQ);

    logic [PtrW-1:0]   r_ptr;
    logic              r_cdb_valid;
    logic [TagW-1:0]   r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;
    logic [N_REQ-1:0]  r_cdb_src;
    logic [7:0]        r_drop_cnt;

    logic              w_found;
    logic [PtrW-1:0]   w_gnt_idx;
    logic [N_REQ-1:0]  w_gnt_oh;
    logic [TagW-1:0]   w_sel_tag;
    logic [DATA_W-1:0] w_sel_data;
    logic [PtrW-1:0]   w_ptr_nxt;
    logic              w_accept;

    // Search ptr, ptr+1, ... with an explicit wrap so N_REQ need not be a power of two.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            int unsigned c;
            c = int'(r_ptr) + k;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            if (!w_found && i_req_valid[c]) begin
                w_found   = 1'b1;
                w_gnt_idx = PtrW'(c);
            end
        end
    end

    always_comb begin
        w_gnt_oh   = '0;
        w_sel_tag  = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_gnt_oh[i] = w_found && (w_gnt_idx == PtrW'(i));
            if (w_gnt_oh[i]) begin
                w_sel_tag  = i_req_tag[i*TagW +: TagW];
                w_sel_data = i_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_nxt   = (w_gnt_idx == PtrW'(N_REQ - 1)) ? '0 : w_gnt_idx + PtrW'(1);
    // A grant is only handed out on an edge that will actually consume it.
    assign w_accept    = i_rdy & ~i_reset;
    assign o_req_ready = w_gnt_oh & {N_REQ{w_accept}};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
            r_drop_cnt  <= '0;
        end else if (i_rdy) begin
            if (i_reset) begin
                // Flush: cancel the broadcast and restart arbitration; the drop count survives.
                r_cdb_valid <= 1'b0;
                r_cdb_src   <= '0;
                r_ptr       <= '0;
            end else if (w_found) begin
                if (w_sel_tag != '0) begin
                    r_cdb_valid <= 1'b1;
                    r_cdb_tag   <= w_sel_tag;
                    r_cdb_data  <= w_sel_data;
                    r_cdb_src   <= w_gnt_oh;
                end else begin
                    r_cdb_valid <= 1'b0;
                    if (r_drop_cnt != 8'hFF) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                end
                r_ptr <= w_ptr_nxt;
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    assign o_cdb_valid = r_cdb_valid;
    assign o_cdb_tag   = r_cdb_tag;
    assign o_cdb_data  = r_cdb_data;
    assign o_cdb_src   = r_cdb_src;
    assign o_drop_cnt  = r_drop_cnt;

endmodule
